// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 3-bit-ALUop ALU: decodes one MIPS ALU instruction, drives the
// ALU for one cycle, returns Result/flags over valid/ready, and keeps perf counters.
module alu_issue_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_opcode,
   input  logic [5:0]       req_funct,
   input  logic [4:0]       req_shamt,
   input  logic [15:0]      req_imm,
   input  logic [31:0]      req_rs_val,
   input  logic [31:0]      req_rt_val,
   output logic [31:0]      alu_A,
   output logic [31:0]      alu_B,
   output logic [2:0]       alu_ALUop,
   input  logic [31:0]      alu_Result,
   input  logic             alu_Zero,
   input  logic             alu_Overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_zero,
   output logic             rsp_overflow,
   output logic             rsp_illegal,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_issued,
   output logic [CNT_W-1:0] cnt_illegal,
   output logic [CNT_W-1:0] cnt_stall
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] RESP = 2'b10;

   logic [1:0]  state;
   logic        trap_q;
   logic        accept;
   logic        dec_legal;
   logic        dec_trap;
   logic [2:0]  dec_op;
   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign imm_sext  = {{16{req_imm[15]}}, req_imm};
   assign imm_zext  = {16'h0000, req_imm};
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   always_comb begin
      dec_legal = 1'b1;
      dec_trap  = 1'b0;
      dec_op    = 3'b000;
      dec_a     = req_rs_val;
      dec_b     = req_rt_val;
      if (req_opcode == 6'b000000) begin
         case (req_funct)
            6'b100100: dec_op = 3'b000;
            6'b100101: dec_op = 3'b001;
            6'b100000: begin dec_op = 3'b010; dec_trap = 1'b1; end
            6'b100001: dec_op = 3'b010;
            6'b100010: begin dec_op = 3'b110; dec_trap = 1'b1; end
            6'b100011: dec_op = 3'b110;
            6'b101010: dec_op = 3'b111;
            6'b101011: dec_op = 3'b100;
            6'b000000: begin
               dec_op = 3'b101;
               dec_a  = req_rt_val;
               dec_b  = {27'd0, req_shamt};
            end
            6'b000100: begin
               dec_op = 3'b101;
               dec_a  = req_rt_val;
               dec_b  = {27'd0, req_rs_val[4:0]};
            end
            default:   dec_legal = 1'b0;
         endcase
      end else begin
         case (req_opcode)
            6'b001001: begin dec_op = 3'b010; dec_b = imm_sext; end
            6'b001100: begin dec_op = 3'b000; dec_b = imm_zext; end
            6'b001101: begin dec_op = 3'b001; dec_b = imm_zext; end
            6'b001010: begin dec_op = 3'b111; dec_b = imm_sext; end
            6'b001011: begin dec_op = 3'b100; dec_b = imm_sext; end
            6'b001111: begin dec_op = 3'b011; dec_b = imm_zext; end
            default:   dec_legal = 1'b0;
         endcase
      end
   end

   // Illegal ops skip EXEC and answer with fixed flags; ALU drive registers keep the last legal op.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         trap_q       <= 1'b0;
         alu_A        <= '0;
         alu_B        <= '0;
         alu_ALUop    <= '0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_illegal  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (dec_legal) begin
                     alu_A     <= dec_a;
                     alu_B     <= dec_b;
                     alu_ALUop <= dec_op;
                     trap_q    <= dec_trap;
                     state     <= EXEC;
                  end else begin
                     rsp_result   <= '0;
                     rsp_zero     <= 1'b1;
                     rsp_overflow <= 1'b0;
                     rsp_illegal  <= 1'b1;
                     state        <= RESP;
                  end
               end
            end
            EXEC: begin
               rsp_result   <= alu_Result;
               rsp_zero     <= alu_Zero;
               rsp_overflow <= alu_Overflow && trap_q;
               rsp_illegal  <= 1'b0;
               state        <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_issued  <= '0;
         cnt_illegal <= '0;
         cnt_stall   <= '0;
      end else if (cnt_clr) begin
         cnt_issued  <= '0;
         cnt_illegal <= '0;
         cnt_stall   <= '0;
      end else begin
         if (accept && dec_legal) begin
            cnt_issued <= cnt_issued + CNT_W'(1);
         end
         if (accept && !dec_legal) begin
            cnt_illegal <= cnt_illegal + CNT_W'(1);
         end
         if (rsp_valid && !rsp_ready) begin
            cnt_stall <= cnt_stall + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: a behavioural ALU answers the DUT, and an
// instruction-level reference model predicts results, flags, latency and counters.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_ready;
   logic [5:0]  req_opcode, req_funct;
   logic [4:0]  req_shamt;
   logic [15:0] req_imm;
   logic [31:0] req_rs_val, req_rt_val;
   logic [31:0] alu_A, alu_B, alu_Result;
   logic [2:0]  alu_ALUop;
   logic        alu_Zero, alu_Overflow;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_overflow, rsp_illegal;
   logic        cnt_clr;
   logic [31:0] cnt_issued, cnt_illegal, cnt_stall;

   int n_checks = 0;
   int n_fail   = 0;

   // reference-side state
   int unsigned m_issued, m_illegal, m_stall;
   logic [31:0] prev_a, prev_b;
   logic [2:0]  prev_op;

   typedef struct {
      logic        legal;
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_funct(req_funct), .req_shamt(req_shamt),
      .req_imm(req_imm), .req_rs_val(req_rs_val), .req_rt_val(req_rt_val),
      .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
      .alu_Result(alu_Result), .alu_Zero(alu_Zero), .alu_Overflow(alu_Overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
      .cnt_clr(cnt_clr), .cnt_issued(cnt_issued),
      .cnt_illegal(cnt_illegal), .cnt_stall(cnt_stall)
   );

   // Behavioural ALU; flags overflow on every add/sub so the controller's gating is exercised.
   always_comb begin
      logic [32:0] t;
      t            = '0;
      alu_Overflow = 1'b0;
      case (alu_ALUop)
         3'b000: alu_Result = alu_A & alu_B;
         3'b001: alu_Result = alu_A | alu_B;
         3'b010: begin
            t = {alu_A[31], alu_A} + {alu_B[31], alu_B};
            alu_Result = t[31:0]; alu_Overflow = t[32] ^ t[31];
         end
         3'b110: begin
            t = {alu_A[31], alu_A} - {alu_B[31], alu_B};
            alu_Result = t[31:0]; alu_Overflow = t[32] ^ t[31];
         end
         3'b111: alu_Result = {31'd0, $signed(alu_A) < $signed(alu_B)};
         3'b011: alu_Result = {alu_B[15:0], 16'h0000};
         3'b100: alu_Result = {31'd0, alu_A < alu_B};
         default: alu_Result = alu_A << alu_B[4:0];
      endcase
      alu_Zero = (alu_Result == 32'd0);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                  input logic [4:0] sh, input logic [15:0] imm,
                                  input logic [31:0] rs, input logic [31:0] rt);
      exp_t e;
      logic [32:0] s;
      logic [31:0] se, ze;
      se = {{16{imm[15]}}, imm};
      ze = {16'h0000, imm};
      e.legal = 1'b1; e.ovf = 1'b0; e.res = '0; e.a = rs; e.b = rt; e.op = 3'b000;
      if (opc == 6'd0) begin
         case (fn)
            6'b100100: begin e.op = 3'b000; e.res = rs & rt; end
            6'b100101: begin e.op = 3'b001; e.res = rs | rt; end
            6'b100000, 6'b100001: begin
               e.op = 3'b010; s = {rs[31], rs} + {rt[31], rt};
               e.res = s[31:0]; e.ovf = (fn == 6'b100000) && (s[32] != s[31]);
            end
            6'b100010, 6'b100011: begin
               e.op = 3'b110; s = {rs[31], rs} - {rt[31], rt};
               e.res = s[31:0]; e.ovf = (fn == 6'b100010) && (s[32] != s[31]);
            end
            6'b101010: begin e.op = 3'b111; e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
            6'b101011: begin e.op = 3'b100; e.res = (rs < rt) ? 32'd1 : 32'd0; end
            6'b000000: begin e.op = 3'b101; e.a = rt; e.b = 32'(sh); e.res = rt << sh; end
            6'b000100: begin e.op = 3'b101; e.a = rt; e.b = 32'(rs[4:0]); e.res = rt << rs[4:0]; end
            default:   e.legal = 1'b0;
         endcase
      end else begin
         case (opc)
            6'b001001: begin e.op = 3'b010; e.b = se; e.res = rs + se; end
            6'b001100: begin e.op = 3'b000; e.b = ze; e.res = rs & ze; end
            6'b001101: begin e.op = 3'b001; e.b = ze; e.res = rs | ze; end
            6'b001010: begin e.op = 3'b111; e.b = se; e.res = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; end
            6'b001011: begin e.op = 3'b100; e.b = se; e.res = (rs < se) ? 32'd1 : 32'd0; end
            6'b001111: begin e.op = 3'b011; e.b = ze; e.res = {imm, 16'h0000}; end
            default:   e.legal = 1'b0;
         endcase
      end
      if (!e.legal) begin
         e.res = '0; e.ovf = 1'b0; e.a = prev_a; e.b = prev_b; e.op = prev_op;
      end
      e.zero = e.legal ? (e.res == 32'd0) : 1'b1;
      return e;
   endfunction

   task automatic do_op(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                        input int stall, input logic clr);
      exp_t e;
      int   lat;
      e = model(opc, fn, sh, imm, rs, rt);
      check_eq("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_opcode = opc; req_funct = fn; req_shamt = sh;
      req_imm = imm; req_rs_val = rs; req_rt_val = rt; cnt_clr = clr;
      @(posedge clk); #1;
      req_valid = 1'b0; cnt_clr = 1'b0;
      req_opcode = 6'($urandom()); req_funct = 6'($urandom());
      req_shamt = 5'($urandom()); req_imm = 16'($urandom());
      req_rs_val = $urandom(); req_rt_val = $urandom();
      if (clr) begin
         m_issued = 0; m_illegal = 0; m_stall = 0;
      end else if (e.legal) m_issued++;
      else m_illegal++;
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("latency", 32'(lat), e.legal ? 32'd2 : 32'd1);
      check_eq("rsp_result", rsp_result, e.res);
      check_eq("rsp_zero", 32'(rsp_zero), 32'(e.zero));
      check_eq("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
      check_eq("rsp_illegal", 32'(rsp_illegal), 32'(!e.legal));
      check_eq("alu_A", alu_A, e.a);
      check_eq("alu_B", alu_B, e.b);
      check_eq("alu_ALUop", 32'(alu_ALUop), 32'(e.op));
      check_eq("cnt_issued", cnt_issued, m_issued);
      check_eq("cnt_illegal", cnt_illegal, m_illegal);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         m_stall++;
         check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         check_eq("stall_req_ready", 32'(req_ready), 32'd0);
         check_eq("stall_rsp_result", rsp_result, e.res);
         check_eq("stall_rsp_flags", {29'd0, rsp_zero, rsp_overflow, rsp_illegal},
                  {29'd0, e.zero, e.ovf, !e.legal});
      end
      check_eq("cnt_stall", cnt_stall, m_stall);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check_eq("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("post_hs_cnt_stall", cnt_stall, m_stall);
      if (e.legal) begin
         prev_a = e.a; prev_b = e.b; prev_op = e.op;
      end
   endtask

   task automatic check_counters(input string tag);
      check_eq({tag, "_issued"}, cnt_issued, m_issued);
      check_eq({tag, "_illegal"}, cnt_illegal, m_illegal);
      check_eq({tag, "_stall"}, cnt_stall, m_stall);
   endtask

   task automatic model_reset();
      m_issued = 0; m_illegal = 0; m_stall = 0;
      prev_a = '0; prev_b = '0; prev_op = '0;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   logic [11:0] legal_tab [16];

   initial begin
      legal_tab = '{12'o0044, 12'o0045, 12'o0040, 12'o0041, 12'o0042, 12'o0043,
                    12'o0052, 12'o0053, 12'o0000, 12'o0004, 12'o1100, 12'o1400,
                    12'o1500, 12'o1200, 12'o1300, 12'o1700};
      resetn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; cnt_clr = 1'b0;
      req_opcode = '0; req_funct = '0; req_shamt = '0; req_imm = '0;
      req_rs_val = '0; req_rt_val = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_req_ready", 32'(req_ready), 32'd1);
      check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("reset_alu", alu_A | alu_B | 32'(alu_ALUop), 32'd0);
      check_eq("reset_rsp", rsp_result | {29'd0, rsp_zero, rsp_overflow, rsp_illegal}, 32'd0);
      check_counters("reset_cnt");
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;

      // directed cases
      do_op(6'd0, 6'b100001, 5'd0, 16'd0, 32'd5, 32'd7, 0, 1'b0);
      do_op(6'd0, 6'b100000, 5'd0, 16'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0);
      do_op(6'd0, 6'b100001, 5'd0, 16'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0);
      do_op(6'd0, 6'b100011, 5'd0, 16'd0, 32'd3, 32'd3, 0, 1'b0);
      do_op(6'b001111, 6'd0, 5'd0, 16'h1234, 32'd0, 32'd0, 0, 1'b0);
      do_op(6'b001010, 6'd0, 5'd0, 16'h0001, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
      do_op(6'b001011, 6'd0, 5'd0, 16'hFFFF, 32'd1, 32'd0, 0, 1'b0);
      do_op(6'd0, 6'b000000, 5'd4, 16'd0, 32'd0, 32'd1, 0, 1'b0);
      do_op(6'b111111, 6'd0, 5'd0, 16'd0, 32'd9, 32'd9, 0, 1'b0);
      do_op(6'd0, 6'b100001, 5'd0, 16'd0, 32'd1, 32'd2, 3, 1'b0);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      model_reset_counts: begin
         m_issued = 0; m_illegal = 0; m_stall = 0;
      end
      check_counters("clr");
      do_op(6'd0, 6'b100101, 5'd0, 16'd0, 32'd1, 32'd2, 2, 1'b1);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         logic [11:0] pick;
         logic [5:0]  opc, fn;
         pick = legal_tab[$urandom_range(0, 15)];
         opc = pick[11:6];
         fn  = pick[5:0];
         if (opc != 6'd0) fn = 6'($urandom());
         if ($urandom_range(0, 4) == 0) begin
            opc = 6'($urandom());
            fn  = 6'($urandom());
         end
         do_op(opc, fn, 5'($urandom()), 16'($urandom()), rand_operand(), rand_operand(),
               int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
      end

      // asynchronous reset while an op is in EXEC
      req_valid = 1'b1; req_opcode = 6'd0; req_funct = 6'b100001;
      req_rs_val = 32'd5; req_rt_val = 32'd7;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check_eq("arst_req_ready", 32'(req_ready), 32'd1);
      check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("arst_alu_A", alu_A, 32'd0);
      check_counters("arst_cnt");
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_eq("arst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      check_eq("arst_ready_after", 32'(req_ready), 32'd1);
      check_counters("arst_cnt_after");
      do_op(6'd0, 6'b100001, 5'd0, 16'd0, 32'd5, 32'd7, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
